// File: rtl/nn_pkg.sv
// Shared constants, opcodes and state encoding for the NN host loader.
package nn_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned W2_DEPTH      = 16;
    localparam int unsigned W2_ADDR_W     = 4;
    localparam int unsigned PIX_W         = 90;
    localparam int unsigned PIX_ROWS      = 10;
    localparam int unsigned WORDS_PER_ROW = (PIX_W + DATA_W - 1) / DATA_W;
    localparam int unsigned WCNT_W        = 3;
    localparam int unsigned ROW_CNT_W     = 4;
    localparam int unsigned OPC_W         = 4;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_LOAD_W2  = 4'd1;
    localparam opcode_t OP_LOAD_PIX = 4'd2;
    localparam opcode_t OP_GO       = 4'd3;
    localparam opcode_t OP_HALT     = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_W2_LOAD  = 2'd1,
        ST_PIX_LOAD = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    // Opcode lives in the top nibble of a command word; the rest is ignored.
    function automatic opcode_t cmd_opcode(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/nn_row_packer.sv
// Packs stream words LSB-first into one pixel row and pulses row_valid when the row is complete.
module nn_row_packer
    import nn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word,
    output logic              at_last_word_c,
    output logic [PIX_W-1:0]  row,
    output logic              row_valid
);

    localparam int unsigned LAST_LO = (WORDS_PER_ROW - 1) * DATA_W;
    localparam int unsigned LAST_W  = PIX_W - LAST_LO;

    logic [WCNT_W-1:0] wcnt;
    logic [PIX_W-1:0]  acc;
    logic [PIX_W-1:0]  acc_d;

    // The incoming word is the last one of the row
    always_comb begin
        at_last_word_c = (wcnt == WCNT_W'(WORDS_PER_ROW - 1));
    end

    // Insert the current word at its slot; the last word's bits above PIX_W-1 are dropped
    always_comb begin
        acc_d = acc;
        for (int k = 0; k < int'(WORDS_PER_ROW) - 1; k++) begin
            if (wcnt == WCNT_W'(k)) begin
                acc_d[k*DATA_W +: DATA_W] = word;
            end
        end
        if (at_last_word_c) begin
            acc_d[PIX_W-1:LAST_LO] = word[LAST_W-1:0];
        end
    end

    // Word counter, partial row and completed-row output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt      <= '0;
            acc       <= '0;
            row       <= '0;
            row_valid <= 1'b0;
        end else begin
            row_valid <= 1'b0;
            if (word_valid) begin
                acc <= acc_d;
                if (at_last_word_c) begin
                    wcnt      <= '0;
                    row       <= acc_d;
                    row_valid <= 1'b1;
                end else begin
                    wcnt <= wcnt + WCNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/nn_host_loader.sv
// Host-side loader: decodes the command stream, writes weight-2 words and pixel rows, controls core reset.
module nn_host_loader
    import nn_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    output logic                 s_ready,
    output logic                 w2_sram_we,
    output logic [DATA_W-1:0]    weight2,
    output logic [W2_ADDR_W-1:0] weight2_addr,
    output logic                 input_sram_we,
    output logic [PIX_W-1:0]     pixels,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t                 state, state_d;
    logic [W2_ADDR_W-1:0]   w2_cnt, w2_cnt_d;
    logic [ROW_CNT_W-1:0]   row_cnt, row_cnt_d;
    logic                   w2_sram_we_d;
    logic [DATA_W-1:0]      weight2_d;
    logic [W2_ADDR_W-1:0]   weight2_addr_d;
    logic                   core_reset_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   err_d;
    logic                   fire_c;
    logic                   pix_word_c;
    logic                   at_last_word_c;

    // Pixel row assembly and the input SRAM write pulse
    nn_row_packer u_packer (
        .clk            (clk),
        .reset          (reset),
        .word_valid     (pix_word_c),
        .word           (s_data),
        .at_last_word_c (at_last_word_c),
        .row            (pixels),
        .row_valid      (input_sram_we)
    );

    // Handshake: a word moves whenever the host offers it and we are ready
    always_comb begin
        fire_c = s_valid & s_ready;
    end

    // Next-state and next-output decode
    always_comb begin
        state_d        = state;
        w2_cnt_d       = w2_cnt;
        row_cnt_d      = row_cnt;
        w2_sram_we_d   = 1'b0;
        weight2_d      = weight2;
        weight2_addr_d = weight2_addr;
        core_reset_d   = core_reset;
        done_d         = 1'b0;
        err_d          = 1'b0;
        pix_word_c     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fire_c) begin
                    case (cmd_opcode(s_data))
                        OP_LOAD_W2: begin
                            state_d  = ST_W2_LOAD;
                            w2_cnt_d = '0;
                        end
                        OP_LOAD_PIX: begin
                            state_d   = ST_PIX_LOAD;
                            row_cnt_d = '0;
                        end
                        OP_GO: begin
                            state_d      = ST_RUN;
                            core_reset_d = 1'b0;
                        end
                        OP_HALT: begin
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            ST_W2_LOAD: begin
                if (fire_c) begin
                    w2_sram_we_d   = 1'b1;
                    weight2_d      = s_data;
                    weight2_addr_d = w2_cnt;
                    w2_cnt_d       = w2_cnt + W2_ADDR_W'(1);
                    if (w2_cnt == W2_ADDR_W'(W2_DEPTH - 1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PIX_LOAD: begin
                if (fire_c) begin
                    pix_word_c = 1'b1;
                    if (at_last_word_c) begin
                        row_cnt_d = row_cnt + ROW_CNT_W'(1);
                        if (row_cnt == ROW_CNT_W'(PIX_ROWS - 1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (fire_c) begin
                    if (cmd_opcode(s_data) == OP_HALT) begin
                        core_reset_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_W2_LOAD) || (state_d == ST_PIX_LOAD);
    end

    // State, counters and registered outputs; every state accepts a word
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            w2_cnt       <= '0;
            row_cnt      <= '0;
            s_ready      <= 1'b1;
            w2_sram_we   <= 1'b0;
            weight2      <= '0;
            weight2_addr <= '0;
            core_reset   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            w2_cnt       <= w2_cnt_d;
            row_cnt      <= row_cnt_d;
            s_ready      <= 1'b1;
            w2_sram_we   <= w2_sram_we_d;
            weight2      <= weight2_d;
            weight2_addr <= weight2_addr_d;
            core_reset   <= core_reset_d;
            busy         <= busy_d;
            done         <= done_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_nn_host_loader.sv
// Directed + randomized bench for nn_host_loader with a word-level reference model.
module tb_nn_host_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        w2_sram_we;
    logic [15:0] weight2;
    logic [3:0]  weight2_addr;
    logic        input_sram_we;
    logic [89:0] pixels;
    logic        core_reset;
    logic        busy;
    logic        done;
    logic        err;

    nn_host_loader dut (
        .clk           (clk),
        .reset         (reset),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .w2_sram_we    (w2_sram_we),
        .weight2       (weight2),
        .weight2_addr  (weight2_addr),
        .input_sram_we (input_sram_we),
        .pixels        (pixels),
        .core_reset    (core_reset),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: what the loader is doing, expressed as burst positions
    localparam int M_IDLE = 0;
    localparam int M_W2   = 1;
    localparam int M_PIX  = 2;
    localparam int M_RUN  = 3;

    int          m_mode;
    int          m_idx;
    int          m_nwords;
    int          m_rows;
    logic [15:0] m_row_words [6];

    logic        e_w2_we;
    logic [15:0] e_weight2;
    logic [3:0]  e_addr;
    logic        e_pix_we;
    logic [89:0] e_pixels;
    logic        e_core_reset;
    logic        e_busy;
    logic        e_done;
    logic        e_err;

    int          w2_pulses;
    int          pix_pulses;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w2_sram_we"},    96'(w2_sram_we),    96'(e_w2_we));
        check({tag, ".weight2"},       96'(weight2),       96'(e_weight2));
        check({tag, ".weight2_addr"},  96'(weight2_addr),  96'(e_addr));
        check({tag, ".input_sram_we"}, 96'(input_sram_we), 96'(e_pix_we));
        check({tag, ".pixels"},        96'(pixels),        96'(e_pixels));
        check({tag, ".core_reset"},    96'(core_reset),    96'(e_core_reset));
        check({tag, ".busy"},          96'(busy),          96'(e_busy));
        check({tag, ".done"},          96'(done),          96'(e_done));
        check({tag, ".err"},           96'(err),           96'(e_err));
        if (w2_sram_we === 1'b1) w2_pulses++;
        if (input_sram_we === 1'b1) pix_pulses++;
    endtask

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_idx        = 0;
        m_nwords     = 0;
        m_rows       = 0;
        e_w2_we      = 1'b0;
        e_weight2    = '0;
        e_addr       = '0;
        e_pix_we     = 1'b0;
        e_pixels     = '0;
        e_core_reset = 1'b1;
        e_busy       = 1'b0;
        e_done       = 1'b0;
        e_err        = 1'b0;
    endtask

    // Expected outputs one cycle after a clock edge, given whether a word w was accepted there
    task automatic model_step(input logic acc, input logic [15:0] w);
        e_w2_we  = 1'b0;
        e_pix_we = 1'b0;
        e_done   = 1'b0;
        e_err    = 1'b0;
        if (acc) begin
            case (m_mode)
                M_IDLE: begin
                    case (int'(w[15:12]))
                        1: begin m_mode = M_W2;  m_idx = 0; end
                        2: begin m_mode = M_PIX; m_nwords = 0; m_rows = 0; end
                        3: begin m_mode = M_RUN; e_core_reset = 1'b0; end
                        4: begin end
                        default: e_err = 1'b1;
                    endcase
                end
                M_W2: begin
                    e_w2_we   = 1'b1;
                    e_weight2 = w;
                    e_addr    = 4'(m_idx);
                    m_idx++;
                    if (m_idx == 16) begin
                        e_done = 1'b1;
                        m_mode = M_IDLE;
                    end
                end
                M_PIX: begin
                    m_row_words[m_nwords] = w;
                    m_nwords++;
                    if (m_nwords == 6) begin
                        e_pixels = {m_row_words[5][9:0], m_row_words[4], m_row_words[3],
                                    m_row_words[2], m_row_words[1], m_row_words[0]};
                        e_pix_we = 1'b1;
                        m_nwords = 0;
                        m_rows++;
                        if (m_rows == 10) begin
                            e_done = 1'b1;
                            m_mode = M_IDLE;
                        end
                    end
                end
                default: begin
                    if (w[15:12] == 4'd4) begin
                        e_core_reset = 1'b1;
                        m_mode       = M_IDLE;
                    end else begin
                        e_err = 1'b1;
                    end
                end
            endcase
        end
        e_busy = (m_mode == M_W2) || (m_mode == M_PIX);
    endtask

    task automatic xfer(input string tag, input logic [15:0] w);
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = w;
        check({tag, ".s_ready"}, 96'(s_ready), 96'(1'b1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        model_step(1'b1, w);
        check_all(tag);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_step(1'b0, 16'h0);
            check_all("gap");
        end
    endtask

    // Reset held for two edges while a GO word is offered; the reset must win
    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h3000;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        s_valid = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        logic [15:0] w;
        int          p0, p1;

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        model_reset();
        w2_pulses  = 0;
        pix_pulses = 0;

        do_reset();
        check("reset.s_ready", 96'(s_ready), 96'(1'b1));

        // GO / HALT / GO: core_reset toggles one cycle after each accept
        xfer("go1", 16'h3000);
        xfer("halt1", 16'h4000);
        xfer("go2", 16'h3000);
        // Load while running is rejected
        xfer("ld_in_run", 16'h1000);
        idle_cycles(1);
        xfer("halt2", 16'h4abc);

        // Illegal opcode in IDLE, then HALT as an IDLE no-op
        xfer("illegal", 16'h7000);
        idle_cycles(1);
        xfer("halt_idle", 16'h4000);

        // Weight-2 burst, back-to-back
        p0 = w2_pulses;
        xfer("ldw2", 16'h1000);
        for (int i = 0; i < 16; i++) xfer("w2_seq", 16'h0100 + 16'(i));
        idle_cycles(2);
        check("w2_seq.pulse_count", 96'(w2_pulses - p0), 96'(16));

        // Weight-2 burst with random payloads and random gaps
        xfer("ldw2r", 16'h1000);
        for (int i = 0; i < 16; i++) begin
            idle_cycles(int'($urandom_range(0, 2)));
            xfer("w2_rand", 16'($urandom));
        end
        idle_cycles(1);

        // Pixel burst with the patterned words and random gaps
        p1 = pix_pulses;
        xfer("ldpix", 16'h2000);
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 6; k++) begin
                idle_cycles(int'($urandom_range(0, 3)));
                w = {4'(r), 4'(k), 8'hA5};
                xfer("pix_pat", w);
            end
        end
        idle_cycles(2);
        check("pix_pat.pulse_count", 96'(pix_pulses - p1), 96'(10));

        // Reset after three words of a row, then a fresh random pixel burst
        xfer("ldpix2", 16'h2000);
        for (int k = 0; k < 3; k++) xfer("pix_partial", 16'hDEAD + 16'(k));
        do_reset();
        xfer("ldpix3", 16'h2000);
        for (int i = 0; i < 60; i++) begin
            idle_cycles(int'($urandom_range(0, 1)));
            xfer("pix_rand", 16'($urandom));
        end
        idle_cycles(1);

        // Reset while running returns the core to held
        xfer("go3", 16'h3000);
        do_reset();
        xfer("go4", 16'h3000);
        xfer("halt3", 16'h4000);
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
